// File: rtl/serializer_pkg.sv
// Shared types and helpers for the buffered serializer.
package serializer_pkg;

  // Shifter states: waiting for a queued word, or driving bits of a word.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  // Width of a length field able to hold every value 0..data_w.
  function automatic int len_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/ser_word_fifo.sv
// Small synchronous FIFO with wrap-bit pointers. Read data is combinational from the
// head entry so the consumer can pop and use the word on the same edge.
module ser_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Same index with different wrap bits means every slot is occupied.
  assign full_o    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty_o   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = push_i && !full_o;
  assign w_do_pop  = pop_i && !empty_o;
  assign rdata_o   = r_mem[r_rd_ptr[AW-1:0]];

  // Storage array: written on push, never reset (contents are qualified by the pointers).
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wdata_i;
    end
  end

  // Pointer update; push and pop may happen together, leaving the count unchanged.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/serializer_buffered.sv
// Buffered parallel-to-serial converter: words arrive over valid/ready, wait in a FIFO,
// and leave as a contiguous 1-bit stream of their first L bits.
module serializer_buffered
  import serializer_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_BITS   = 3,
  parameter bit MSB_FIRST  = 1'b1,
  localparam int MOD_W     = $clog2(DATA_W)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              data_ready_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);

  localparam int LEN_W = len_w(DATA_W);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LEN_W-1:0]  len;
  } ser_entry_t;

  logic [1:0]        r_rst_sync;
  logic              w_rst_n;
  ser_state_t        r_state;
  logic [DATA_W-1:0] r_shift;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_ser_data;
  logic              r_ser_val;
  logic              r_busy;

  logic [LEN_W-1:0]  w_len;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  ser_entry_t        w_wr_entry;
  ser_entry_t        w_rd_entry;
  logic              w_out_bit;
  logic [DATA_W-1:0] w_shift_next;

  // Reset asserts immediately and releases two edges after arst_n_i rises.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_rst_sync <= 2'b00;
    else           r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // A modifier of 0 selects the full word; too-short words are accepted then discarded.
  assign w_len        = (data_mod_i == '0) ? LEN_W'(DATA_W) : LEN_W'(data_mod_i);
  assign w_drop       = (w_len < LEN_W'(MIN_BITS));
  assign data_ready_o = w_rst_n && !w_full;
  assign w_push       = data_val_i && data_ready_o && !w_drop;
  assign w_wr_entry   = '{data: data_i, len: w_len};

  // Pop when idle, or on the last bit of the current word for a gapless hand-over.
  assign w_pop = !w_empty && ((r_state == IDLE) || (r_cnt == LEN_W'(1)));

  ser_word_fifo #(
    .WIDTH ($bits(ser_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .arst_n_i (w_rst_n),
    .push_i   (w_push),
    .wdata_i  (w_wr_entry),
    .pop_i    (w_pop),
    .rdata_o  (w_rd_entry),
    .full_o   (w_full),
    .empty_o  (w_empty)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_out_bit    = r_shift[DATA_W-1];
      assign w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_out_bit    = r_shift[0];
      assign w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
    end
  endgenerate

  // Shifter FSM with registered serial outputs and busy flag.
  always_ff @(posedge clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_ser_data <= 1'b0;
      r_ser_val  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_busy     <= (r_state == SHIFT) || !w_empty;
      r_ser_data <= 1'b0;
      r_ser_val  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_shift <= w_rd_entry.data;
            r_cnt   <= w_rd_entry.len;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_ser_data <= w_out_bit;
          r_ser_val  <= 1'b1;
          if (r_cnt == LEN_W'(1)) begin
            if (w_pop) begin
              r_shift <= w_rd_entry.data;
              r_cnt   <= w_rd_entry.len;
            end else begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end
          end else begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ser_data_o     = r_ser_data;
  assign ser_data_val_o = r_ser_val;
  assign busy_o         = r_busy;

endmodule

// File: tb/tb_serializer_buffered.sv
// Directed bench for serializer_buffered: one MSB-first and one LSB-first instance,
// expected bits queued at handshake time and compared as they appear on the stream.
module tb_serializer_buffered;

  logic        clk    = 1'b0;
  logic        arst_n = 1'b1;
  logic [15:0] data   = '0;
  logic [3:0]  mod    = '0;
  logic        val_m  = 1'b0;
  logic        val_l  = 1'b0;
  logic        m_ready, m_data, m_val, m_busy;
  logic        l_ready, l_data, l_val, l_busy;

  int errors   = 0;
  int checks   = 0;
  int run_len  = 0;
  int last_run = 0;
  bit q_msb[$];
  bit q_lsb[$];

  always #5 clk = ~clk;

  serializer_buffered #(.DATA_W(16), .FIFO_DEPTH(4), .MIN_BITS(3), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(data), .data_mod_i(mod), .data_val_i(val_m),
    .data_ready_o(m_ready), .ser_data_o(m_data), .ser_data_val_o(m_val), .busy_o(m_busy)
  );

  serializer_buffered #(.DATA_W(16), .FIFO_DEPTH(4), .MIN_BITS(3), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk_i(clk), .arst_n_i(arst_n), .data_i(data), .data_mod_i(mod), .data_val_i(val_l),
    .data_ready_o(l_ready), .ser_data_o(l_data), .ser_data_val_o(l_val), .busy_o(l_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected serial bits of a word, derived from data, modifier and bit order.
  task automatic expect_word(input logic [15:0] d, input logic [3:0] m, input bit lsb);
    int len;
    len = (m == 4'd0) ? 16 : int'(m);
    if (len < 3) return;
    for (int i = 0; i < len; i++) begin
      if (lsb) q_lsb.push_back(d[i]);
      else     q_msb.push_back(d[15-i]);
    end
  endtask

  // One clock: advance past the rising edge, then sample both streams on the falling edge.
  task automatic tick();
    bit e;
    @(posedge clk);
    @(negedge clk);
    if (m_val) begin
      check("msb_bit_expected", 32'(q_msb.size() != 0), 1);
      if (q_msb.size() != 0) begin
        e = q_msb.pop_front();
        check("msb_bit", m_data, e);
      end
      run_len++;
    end else begin
      check("msb_idle_data_zero", m_data, 0);
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
    if (l_val) begin
      check("lsb_bit_expected", 32'(q_lsb.size() != 0), 1);
      if (q_lsb.size() != 0) begin
        e = q_lsb.pop_front();
        check("lsb_bit", l_data, e);
      end
    end else begin
      check("lsb_idle_data_zero", l_data, 0);
    end
  endtask

  // Present a word and hold it until the handshake completes.
  task automatic push(input logic [15:0] d, input logic [3:0] m, input bit lsb);
    bit rdy;
    bit accepted;
    accepted = 0;
    data = d;
    mod  = m;
    if (lsb) val_l = 1'b1; else val_m = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rdy = lsb ? l_ready : m_ready;
      tick();
      if (rdy) begin
        accepted = 1;
        expect_word(d, m, lsb);
        break;
      end
    end
    val_l = 1'b0;
    val_m = 1'b0;
    check("push_accepted", 32'(accepted), 1);
  endtask

  task automatic wait_drain(input string tag);
    bit done;
    done = 0;
    for (int n = 0; n < 400; n++) begin
      if (q_msb.size() == 0 && q_lsb.size() == 0 && !m_busy && !l_busy && !m_val && !l_val) begin
        done = 1;
        break;
      end
      tick();
    end
    check(tag, 32'(done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset asserted between edges: outputs drop at once.
    #1 arst_n = 1'b0;
    #2;
    check("rst_ready_msb", m_ready, 0);
    check("rst_ready_lsb", l_ready, 0);
    check("rst_val", m_val, 0);
    check("rst_data", m_data, 0);
    check("rst_busy", m_busy, 0);
    tick();
    tick();
    arst_n = 1'b1;
    tick(); tick(); tick();
    check("ready_after_release_msb", m_ready, 1);
    check("ready_after_release_lsb", l_ready, 1);
    check("busy_after_release", m_busy, 0);
    $display("step reset: ready=%0b busy=%0b", m_ready, m_busy);

    // Full word, MSB first, with latency and busy timing.
    push(16'hF0F0, 4'd0, 1'b0);
    check("lat_edge_k_val", m_val, 0);
    check("lat_edge_k_busy", m_busy, 0);
    tick();
    check("lat_edge_k1_busy", m_busy, 1);
    check("lat_edge_k1_val", m_val, 0);
    tick();
    check("lat_edge_k2_val", m_val, 1);
    wait_drain("drain_full_word");
    check("full_word_run", last_run, 16);
    check("full_word_busy_drop", m_busy, 0);
    $display("step full word F0F0: run=%0d", last_run);

    // Short word of 5 bits.
    push(16'hA800, 4'd5, 1'b0);
    wait_drain("drain_short");
    check("short_run", last_run, 5);
    $display("step short A800 mod5: run=%0d", last_run);

    // Words below the minimum length are taken but never shifted.
    push(16'hFFFF, 4'd2, 1'b0);
    push(16'hFFFF, 4'd1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("drop_busy_msb", m_busy, 0);
      check("drop_busy_lsb", l_busy, 0);
    end
    $display("step dropped mod2/mod1: busy=%0b/%0b", m_busy, l_busy);

    // Back-to-back words leave as one gapless run.
    push(16'hA5C3, 4'd3, 1'b0);
    push(16'h3C96, 4'd4, 1'b0);
    push(16'hDEAD, 4'd0, 1'b0);
    push(16'h1234, 4'd7, 1'b0);
    wait_drain("drain_b2b");
    check("b2b_run", last_run, 30);
    $display("step back-to-back 3+4+16+7: run=%0d", last_run);

    // LSB-first instance.
    push(16'h0005, 4'd4, 1'b1);
    wait_drain("drain_lsb_short");
    push(16'hC3A5, 4'd0, 1'b1);
    wait_drain("drain_lsb_full");
    $display("step lsb 0005 mod4 and C3A5 mod0 done");

    // Fill the queue behind a long word; the sixth word waits for space.
    push(16'h1111, 4'd0, 1'b0);
    push(16'h2222, 4'd0, 1'b0);
    push(16'h3333, 4'd0, 1'b0);
    push(16'h4444, 4'd0, 1'b0);
    push(16'h5555, 4'd0, 1'b0);
    check("full_ready_low", m_ready, 0);
    check("full_busy", m_busy, 1);
    push(16'h6666, 4'd0, 1'b0);
    wait_drain("drain_fill");
    check("fill_run", last_run, 96);
    $display("step fill 6 words: run=%0d", last_run);

    // Reset in the middle of a word abandons it and the queue.
    push(16'hF0F0, 4'd0, 1'b0);
    push(16'h0FF0, 4'd0, 1'b0);
    for (int n = 0; n < 100 && q_msb.size() > 26; n++) tick();
    check("midrst_progress", q_msb.size(), 26);
    #2 arst_n = 1'b0;
    #1;
    check("midrst_val", m_val, 0);
    check("midrst_data", m_data, 0);
    check("midrst_busy", m_busy, 0);
    check("midrst_ready", m_ready, 0);
    q_msb.delete();
    q_lsb.delete();
    run_len = 0;
    tick();
    tick();
    arst_n = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("midrst_ready_after", m_ready, 1);
    check("midrst_busy_after", m_busy, 0);
    check("midrst_no_bits", run_len, 0);
    $display("step reset mid-word: ready=%0b busy=%0b", m_ready, m_busy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
